// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine change path.
//   state_t    : change_dispenser FSM states
//   den_idx_t  : denomination / tube index (0 = largest coin)
//   DEF_DEN*   : default coin values, strictly decreasing
package vm_pkg;

  typedef enum logic [1:0] {IDLE, SELECT, REQ, DONE} state_t;

  typedef logic [1:0] den_idx_t;

  localparam int unsigned NUM_DEN  = 4;
  localparam int unsigned DEF_DEN0 = 20;
  localparam int unsigned DEF_DEN1 = 10;
  localparam int unsigned DEF_DEN2 = 5;
  localparam int unsigned DEF_DEN3 = 1;

endpackage

// File: rtl/change_dispenser_inventory.sv
// coin_inventory: one coin counter per denomination tube.
//   clk, reset   : clock, synchronous active-high reset (all tubes full)
//   dec_en/idx   : remove one coin from tube dec_idx (saturates at 0)
//   refill/sel   : load tube refill_sel with INV_MAX (wins over a decrement)
//   inv_empty    : bit i high when tube i holds no coins
//   inv_nonzero  : complement of inv_empty
module coin_inventory
  import vm_pkg::*;
#(
  parameter int unsigned INV_MAX = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_en,
  input  den_idx_t             dec_idx,
  input  logic                 refill,
  input  den_idx_t             refill_sel,
  output logic [NUM_DEN-1:0]   inv_empty,
  output logic [NUM_DEN-1:0]   inv_nonzero
);

  localparam int unsigned CW = $clog2(INV_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(INV_MAX);

  logic [CW-1:0] count [NUM_DEN];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_DEN; i++) count[i] <= FULL;
    end else begin
      for (int unsigned i = 0; i < NUM_DEN; i++) begin
        if (refill && refill_sel == den_idx_t'(i))
          count[i] <= FULL;
        else if (dec_en && dec_idx == den_idx_t'(i) && count[i] != '0)
          count[i] <= count[i] - 1'b1;
      end
    end
  end

  always_comb begin
    inv_empty = '0;
    for (int unsigned i = 0; i < NUM_DEN; i++) inv_empty[i] = (count[i] == '0);
  end

  assign inv_nonzero = ~inv_empty;

endmodule

// File: rtl/change_dispenser.sv
// change_dispenser: pays out a change amount one coin at a time, greedy
// (largest available denomination first), over a req/ack hopper handshake.
//   clk, reset          : clock, synchronous active-high reset
//   change_valid/change : 1-cycle strobe with 8-bit amount to pay
//   coin_ack            : hopper dropped one coin of coin_sel
//   refill/refill_sel   : reload one tube to INV_MAX
//   busy                : payout in progress (through the done cycle)
//   coin_req/coin_sel   : request one coin of tube coin_sel
//   dispense_done       : 1-cycle end-of-payout pulse
//   shortfall           : unpaid remainder, held until next accept
//   fault               : sticky hopper timeout
//   inv_empty           : per-tube empty flags
module change_dispenser
  import vm_pkg::*;
#(
  parameter int unsigned DEN0        = DEF_DEN0,
  parameter int unsigned DEN1        = DEF_DEN1,
  parameter int unsigned DEN2        = DEF_DEN2,
  parameter int unsigned DEN3        = DEF_DEN3,
  parameter int unsigned INV_MAX     = 15,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [7:0] change,
  input  logic       coin_ack,
  input  logic       refill,
  input  logic [1:0] refill_sel,
  output logic       busy,
  output logic       coin_req,
  output logic [1:0] coin_sel,
  output logic       dispense_done,
  output logic [7:0] shortfall,
  output logic       fault,
  output logic [3:0] inv_empty
);

  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

  state_t              state;
  logic [7:0]          remaining;
  logic [TW-1:0]       tcnt;
  logic [NUM_DEN-1:0]  inv_nonzero;
  logic                pick_ok;
  den_idx_t            pick_idx;
  logic                take_coin;

  function automatic logic [7:0] den_of(input den_idx_t idx);
    case (idx)
      2'd0:    den_of = 8'(DEN0);
      2'd1:    den_of = 8'(DEN1);
      2'd2:    den_of = 8'(DEN2);
      default: den_of = 8'(DEN3);
    endcase
  endfunction

  // Lowest index that fits and is stocked; remaining==0 never matches
  // because every denomination is nonzero.
  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_DEN; i++) begin
      if (!pick_ok && den_of(den_idx_t'(i)) <= remaining && inv_nonzero[i]) begin
        pick_ok  = 1'b1;
        pick_idx = den_idx_t'(i);
      end
    end
  end

  assign take_coin = (state == REQ) && coin_ack;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      shortfall <= '0;
      coin_sel  <= '0;
      fault     <= 1'b0;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (change_valid && !fault) begin
            remaining <= change;
            shortfall <= '0;
            state     <= SELECT;
          end
        end
        SELECT: begin
          if (pick_ok) begin
            coin_sel <= pick_idx;
            tcnt     <= '0;
            state    <= REQ;
          end else begin
            shortfall <= remaining;
            state     <= DONE;
          end
        end
        REQ: begin
          if (coin_ack) begin
            remaining <= remaining - den_of(coin_sel);
            state     <= SELECT;
          end else if (tcnt == T_LAST) begin
            fault     <= 1'b1;
            shortfall <= remaining;
            state     <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy          = (state != IDLE);
  assign coin_req      = (state == REQ);
  assign dispense_done = (state == DONE);

  coin_inventory #(
    .INV_MAX (INV_MAX)
  ) u_inv (
    .clk         (clk),
    .reset       (reset),
    .dec_en      (take_coin),
    .dec_idx     (coin_sel),
    .refill      (refill),
    .refill_sel  (refill_sel),
    .inv_empty   (inv_empty),
    .inv_nonzero (inv_nonzero)
  );

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  localparam int INV_MAX = 15;
  localparam int ACK_TO  = 64;

  logic       clk = 1'b0;
  logic       reset;
  logic       change_valid;
  logic [7:0] change;
  logic       coin_ack;
  logic       refill;
  logic [1:0] refill_sel;
  logic       busy;
  logic       coin_req;
  logic [1:0] coin_sel;
  logic       dispense_done;
  logic [7:0] shortfall;
  logic       fault;
  logic [3:0] inv_empty;

  int n_cmp  = 0;
  int n_fail = 0;

  int exp_coin  [$];
  int exp_short [$];
  int minv [4];
  int den  [4] = '{20, 10, 5, 1};

  change_dispenser #(
    .DEN0        (20),
    .DEN1        (10),
    .DEN2        (5),
    .DEN3        (1),
    .INV_MAX     (INV_MAX),
    .ACK_TIMEOUT (ACK_TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .change_valid  (change_valid),
    .change        (change),
    .coin_ack      (coin_ack),
    .refill        (refill),
    .refill_sel    (refill_sel),
    .busy          (busy),
    .coin_req      (coin_req),
    .coin_sel      (coin_sel),
    .dispense_done (dispense_done),
    .shortfall     (shortfall),
    .fault         (fault),
    .inv_empty     (inv_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference payout: greedy over stocked tubes, pushes expectations.
  function automatic int model_push(input int amt);
    int rem;
    int n;
    bit found;
    rem = amt;
    n   = 0;
    do begin
      found = 0;
      for (int i = 0; i < 4; i++) begin
        if (!found && den[i] <= rem && minv[i] > 0) begin
          found = 1;
          exp_coin.push_back(i);
          rem = rem - den[i];
          minv[i] = minv[i] - 1;
          n++;
        end
      end
    end while (found);
    exp_short.push_back(rem);
    return n;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) minv[i] = INV_MAX;
    exp_coin.delete();
    exp_short.delete();
  endtask

  // One payout with an immediately-acking hopper; scoreboard checks coins,
  // shortfall, busy and done latency.
  task automatic run_change(input int amt, input bit inject, input bit refill_on_ack2,
                            output int done_at);
    bit finished;
    bit prev_req;
    int ncoins;
    int e;
    ncoins  = model_push(amt);
    done_at = -1;
    @(negedge clk);
    change       = 8'(amt);
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_accept amt=%0d: got %b want 1", amt, busy);
    end
    finished = 0;
    prev_req = 0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      change_valid = 1'b0;
      coin_ack     = 1'b0;
      refill       = 1'b0;
      if (coin_req === 1'b1 && !prev_req) begin
        n_cmp++;
        if (exp_coin.size() == 0) begin
          n_fail++;
          $display("FAIL coin_extra amt=%0d: got coin %0d want none", amt, coin_sel);
        end else begin
          e = exp_coin.pop_front();
          if (coin_sel !== 2'(e)) begin
            n_fail++;
            $display("FAIL coin_sel amt=%0d: got %0d want %0d", amt, coin_sel, e);
          end
        end
      end
      if (coin_req === 1'b1) begin
        coin_ack = 1'b1;
        if (refill_on_ack2 && coin_sel == 2'd2) begin
          refill     = 1'b1;
          refill_sel = 2'd2;
        end
      end
      if (inject && cyc == 1) begin
        change_valid = 1'b1;
        change       = 8'd100;
      end
      if (dispense_done === 1'b1) begin
        finished = 1;
        done_at  = cyc;
        e = exp_short.pop_front();
        n_cmp++;
        if (shortfall !== 8'(e)) begin
          n_fail++;
          $display("FAIL shortfall amt=%0d: got %0d want %0d", amt, shortfall, e);
        end
        n_cmp++;
        if (done_at != 2 * ncoins + 1) begin
          n_fail++;
          $display("FAIL done_latency amt=%0d: got %0d want %0d", amt, done_at, 2 * ncoins + 1);
        end
      end
      prev_req = (coin_req === 1'b1);
      @(negedge clk);
    end
    coin_ack     = 1'b0;
    refill       = 1'b0;
    change_valid = 1'b0;
    if (!finished) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout amt=%0d: got no dispense_done want one", amt);
      exp_short.delete();
    end
    n_cmp++;
    if (exp_coin.size() != 0) begin
      n_fail++;
      $display("FAIL coins_missing amt=%0d: got %0d left want 0", amt, exp_coin.size());
      exp_coin.delete();
    end
    n_cmp++;
    if (dispense_done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_done amt=%0d: got done=%b busy=%b want 0 0", amt, dispense_done, busy);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({busy, coin_req, dispense_done, fault} !== 4'b0000 || shortfall !== 8'd0 ||
        inv_empty !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_state: got busy=%b req=%b done=%b fault=%b short=%0d empty=%b want all 0",
               busy, coin_req, dispense_done, fault, shortfall, inv_empty);
    end
  endtask

  task automatic test_greedy();
    int d;
    run_change(35, 0, 0, d);
  endtask

  task automatic test_zero();
    int d;
    run_change(0, 0, 0, d);
    n_cmp++;
    if (d != 1) begin
      n_fail++;
      $display("FAIL zero_latency: got done at %0d want 1 (2 cycles after strobe)", d);
    end
  endtask

  task automatic test_busy_ignore();
    int d;
    run_change(35, 1, 0, d);
  endtask

  task automatic test_skip_empty();
    int d;
    while (minv[1] > 0) run_change(10, 0, 0, d);
    n_cmp++;
    if (inv_empty !== 4'b0010) begin
      n_fail++;
      $display("FAIL inv_empty_tube1: got %b want 0010", inv_empty);
    end
    run_change(30, 0, 0, d);
  endtask

  task automatic test_shortfall();
    int d;
    while (minv[3] > 0) run_change(1, 0, 0, d);
    n_cmp++;
    if (inv_empty !== 4'b1010) begin
      n_fail++;
      $display("FAIL inv_empty_tube13: got %b want 1010", inv_empty);
    end
    run_change(23, 0, 0, d);
    @(negedge clk);
    refill     = 1'b1;
    refill_sel = 2'd1;
    @(negedge clk);
    refill = 1'b0;
    minv[1] = INV_MAX;
    n_cmp++;
    if (inv_empty !== 4'b1000) begin
      n_fail++;
      $display("FAIL refill_tube1: got %b want 1000", inv_empty);
    end
  endtask

  task automatic test_refill_collision();
    int d;
    run_change(5, 0, 1, d);
    minv[2] = INV_MAX;
    n_cmp++;
    if (dut.u_inv.count[2] !== 4'(INV_MAX)) begin
      n_fail++;
      $display("FAIL refill_wins: got count %0d want %0d", dut.u_inv.count[2], INV_MAX);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    bit finished;
    @(negedge clk);
    change       = 8'd45;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    req_cycles = 0;
    finished   = 0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (coin_req === 1'b1) req_cycles++;
      if (dispense_done === 1'b1) begin
        finished = 1;
        n_cmp++;
        if (shortfall !== 8'd45 || fault !== 1'b1) begin
          n_fail++;
          $display("FAIL timeout_result: got short=%0d fault=%b want 45 1", shortfall, fault);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!finished || req_cycles != ACK_TO) begin
      n_fail++;
      $display("FAIL timeout_req_cycles: got %0d (done=%0d) want %0d", req_cycles, finished, ACK_TO);
    end
    change       = 8'd10;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    finished = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (busy !== 1'b0 || coin_req !== 1'b0) finished = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (finished || fault !== 1'b1) begin
      n_fail++;
      $display("FAIL fault_blocks: got started=%0d fault=%b want 0 1", finished, fault);
    end
    do_reset();
    n_cmp++;
    if (fault !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_clear: got %b want 0", fault);
    end
  endtask

  task automatic test_reset_mid_req();
    bit saw_req;
    bit saw_done;
    @(negedge clk);
    change       = 8'd20;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    saw_req = 0;
    for (int cyc = 0; cyc < 10 && !saw_req; cyc++) begin
      if (coin_req === 1'b1) saw_req = 1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!saw_req) begin
      n_fail++;
      $display("FAIL mid_req_start: got no coin_req want coin_req");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (coin_req !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_req_abort: got req=%b busy=%b want 0 0", coin_req, busy);
    end
    saw_done = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (dispense_done !== 1'b0) saw_done = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL mid_req_no_done: got dispense_done want none");
    end
    for (int i = 0; i < 4; i++) minv[i] = INV_MAX;
  endtask

  initial begin
    reset        = 1'b1;
    change_valid = 1'b0;
    change       = 8'd0;
    coin_ack     = 1'b0;
    refill       = 1'b0;
    refill_sel   = 2'd0;
    test_reset();
    test_greedy();
    test_zero();
    test_busy_ignore();
    test_skip_empty();
    test_shortfall();
    test_refill_collision();
    test_timeout();
    test_reset_mid_req();
    test_greedy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
